// File: rtl/sd_test_pkg.sv
// Shared definitions for the SD test datapath: sector size, checker state
// encoding and the byte pattern written by the write engine.
package sd_test_pkg;

  localparam int SD_BLOCK_BYTES = 512;
  localparam int CHK_CNT_W      = 10;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_ARMED = 2'd1,
    CHK_CHECK = 2'd2,
    CHK_DONE  = 2'd3
  } chk_state_t;

  // Test pattern: byte at index i of a sector holds i mod 256.
  function automatic logic [7:0] sd_pattern_byte(input int idx);
    return 8'(idx % 256);
  endfunction

endpackage

// File: rtl/sd_chk_timeout.sv
// Watchdog counter for the data checker: cleared on activity, counts idle
// cycles while enabled and flags the cycle on which the limit is reached.
module sd_chk_timeout #(
  parameter int TIMEOUT_CYC = 1048576,
  parameter int TO_W        = 21
) (
  input  logic SD_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_W-1:0] count;

  always_ff @(posedge SD_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle so the abort lands
  // exactly TIMEOUT_CYC cycles after the last activity.
  assign expire = en & ~clr & (count == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/sd_data_check.sv
// Sector checker: compares the read engine's byte stream against the write
// test pattern and latches a verdict with error/underrun/overrun/timeout detail.
module sd_data_check
  import sd_test_pkg::*;
#(
  parameter int BLOCK_BYTES = SD_BLOCK_BYTES,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int TO_W        = 21
) (
  input  logic             SD_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       mydata_i,
  input  logic             myvalid_i,
  input  logic             read_done_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [9:0]       err_cnt,
  output logic [9:0]       first_err_idx,
  output logic [7:0]       first_err_data,
  output logic [9:0]       byte_cnt,
  output logic             underrun,
  output logic             overrun,
  output logic             timeout,
  output chk_state_t       dbg_state
);

  // Handshake: a byte is transferred on every cycle myvalid_i is high (no
  // back-pressure); read_done_i is a single-cycle strobe that may coincide
  // with the final byte, which is then counted before the verdict is formed.

  chk_state_t state, state_nx;

  logic       active;
  logic       take;
  logic       room;
  logic       accept;
  logic       ovf;
  logic       mism;
  logic       finish;
  logic       to_clr;
  logic       to_expire;
  logic [9:0] byte_cnt_nx;
  logic [9:0] err_cnt_nx;
  logic       overrun_nx;
  logic       underrun_nx;

  assign active      = (state == CHK_ARMED) || (state == CHK_CHECK);
  assign take        = active & myvalid_i & ~start;
  assign room        = int'(byte_cnt) < BLOCK_BYTES;
  assign accept      = take & room;
  assign ovf         = take & ~room;
  assign mism        = accept & (mydata_i != sd_pattern_byte(int'(byte_cnt)));
  assign byte_cnt_nx = byte_cnt + 10'(accept);
  assign err_cnt_nx  = err_cnt + 10'(mism);
  assign overrun_nx  = overrun | ovf;
  assign underrun_nx = int'(byte_cnt_nx) < BLOCK_BYTES;
  assign finish      = active & ~start & (read_done_i | to_expire);
  assign to_clr      = start | (active & myvalid_i);

  sd_chk_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .SD_clk (SD_clk),
    .rst    (rst),
    .clr    (to_clr),
    .en     (active),
    .expire (to_expire)
  );

  always_ff @(posedge SD_clk or posedge rst) begin
    if (rst) begin
      state <= CHK_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = CHK_ARMED;
    end else begin
      case (state)
        CHK_IDLE:  state_nx = CHK_IDLE;
        CHK_ARMED: begin
          if (read_done_i || to_expire) state_nx = CHK_DONE;
          else if (myvalid_i)           state_nx = CHK_CHECK;
        end
        CHK_CHECK: begin
          if (read_done_i || to_expire) state_nx = CHK_DONE;
        end
        CHK_DONE:  state_nx = CHK_IDLE;
        default:   state_nx = CHK_IDLE;
      endcase
    end
  end

  always_ff @(posedge SD_clk or posedge rst) begin
    if (rst) begin
      byte_cnt       <= '0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      overrun        <= 1'b0;
      underrun       <= 1'b0;
      timeout        <= 1'b0;
      pass           <= 1'b0;
    end else if (start) begin
      byte_cnt       <= '0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      overrun        <= 1'b0;
      underrun       <= 1'b0;
      timeout        <= 1'b0;
      pass           <= 1'b0;
    end else if (active) begin
      byte_cnt <= byte_cnt_nx;
      err_cnt  <= err_cnt_nx;
      overrun  <= overrun_nx;
      if (mism && (err_cnt == '0)) begin
        first_err_idx  <= byte_cnt;
        first_err_data <= mydata_i;
      end
      // Verdict uses the post-update counts so a byte coinciding with
      // read_done_i is included.
      if (finish) begin
        timeout  <= to_expire;
        underrun <= underrun_nx;
        pass     <= (err_cnt_nx == '0) & ~underrun_nx & ~overrun_nx & ~to_expire;
      end
    end
  end

  assign busy      = active;
  assign done      = (state == CHK_DONE);
  assign dbg_state = state;

endmodule
